sys_cfg_bank: RTL



---
 rtl/sys_cfg_bank_if.sv | 14 +
 rtl/sys_cfg_bank.sv | 136 +++++++++++++
 2 files changed

// File: rtl/sys_cfg_bank_if.sv
// PI bus view of the config bank: decoder drives the cycle, bank returns readback.
interface sys_cfg_bank_if #(
    parameter int AW = 5
);
    logic          pi_act;
    logic          pi_we;
    logic          pi_ce_cfg;
    logic [AW-1:0] pi_addr;
    logic [7:0]    pi_dato;
    logic [7:0]    pi_di;

    modport master (output pi_act, pi_we, pi_ce_cfg, pi_addr, pi_dato, input pi_di);
    modport slave  (input pi_act, pi_we, pi_ce_cfg, pi_addr, pi_dato, output pi_di);
endinterface

// File: rtl/sys_cfg_bank.sv
// Double-buffered system config register file: PI writes land in a staging
// bank, a live bank drives the decoded mapper outputs, and staging is copied
// to live atomically on commit (or tracked write-by-write when DEFER = 0).
module sys_cfg_bank #(
    parameter int REGS    = 16,
    parameter bit DEFER   = 1'b1,
    parameter int CMT_IDX = REGS - 1,
    parameter int PRG_MW  = 10,
    parameter int SRM_MW  = 11,
    parameter int CHR_MW  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    sys_cfg_bank_if.slave     pi,
    input  logic              cmt_req,
    output logic              dirty,
    output logic              cmt_ack,
    output logic [11:0]       map_idx,
    output logic [PRG_MW-1:0] prg_msk,
    output logic [SRM_MW-1:0] srm_msk,
    output logic [CHR_MW-1:0] chr_msk,
    output logic [18:0]       srm_size,
    output logic [7:0]        ctrl,
    output logic [7:0]        map_cfg
);
    localparam int            IW    = $clog2(REGS);
    localparam logic [IW-1:0] CMT_I = IW'(CMT_IDX);

    typedef enum logic [1:0] {S_IDLE, S_PEND, S_EXEC} state_t;

    state_t        r_state, w_state_nxt;
    logic          r_wr_v;
    logic [IW-1:0] r_wr_idx;
    logic [7:0]    r_wr_dat;
    logic [7:0]    r_stg  [REGS];
    logic [7:0]    r_live [REGS];
    logic          r_dirty;
    logic [7:0]    r_di;

    logic          w_land;
    logic          w_cmt_wr;
    logic          w_req;
    logic          w_exec;
    logic [IW-1:0] w_rd_idx;
    logic [3:0]    w_prg_n, w_srm_n, w_chr_n;

    // The commit register index is a trigger only; it never lands in staging.
    assign w_land   = r_wr_v && (r_wr_idx != CMT_I);
    assign w_cmt_wr = r_wr_v && (r_wr_idx == CMT_I) && (r_wr_dat == 8'hA5);
    assign w_req    = cmt_req | w_cmt_wr;
    // Holding off while a write lands guarantees that write is in the snapshot.
    assign w_exec   = (r_state == S_PEND) && !w_land;
    assign w_rd_idx = pi.pi_addr[IW-1:0];

    // Write capture stage; writes aimed at the live bank (MSB set) are dropped here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_v   <= 1'b0;
            r_wr_idx <= '0;
            r_wr_dat <= '0;
        end else begin
            r_wr_v   <= pi.pi_act & pi.pi_we & pi.pi_ce_cfg & ~pi.pi_addr[IW];
            r_wr_idx <= pi.pi_addr[IW-1:0];
            r_wr_dat <= pi.pi_dato;
        end
    end

    // Staging bank: the only PI-writable storage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < REGS; i++) r_stg[i] <= '0;
        end else if (w_land) begin
            r_stg[r_wr_idx] <= r_wr_dat;
        end
    end

    // Live bank: whole-bank snapshot on commit, or per-write follow in immediate mode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < REGS; i++) r_live[i] <= '0;
        end else if (w_exec) begin
            for (int i = 0; i < REGS; i++) r_live[i] <= r_stg[i];
        end else if (!DEFER && w_land) begin
            r_live[r_wr_idx] <= r_wr_dat;
        end
    end

    // Dirty tracking; a landing write wins over a commit clearing it.
    always_ff @(posedge clk) begin
        if (!rst_n)                r_dirty <= 1'b0;
        else if (DEFER && w_land)  r_dirty <= 1'b1;
        else if (w_exec)           r_dirty <= 1'b0;
    end

    // Commit FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Commit FSM next state; a request arriving during EXEC is kept, not lost.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_req) w_state_nxt = S_PEND;
            S_PEND:  if (!w_land) w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = w_req ? S_PEND : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Registered readback from the bank selected by the address MSB.
    always_ff @(posedge clk) begin
        if (!rst_n) r_di <= '0;
        else        r_di <= pi.pi_addr[IW] ? r_live[w_rd_idx] : r_stg[w_rd_idx];
    end

    assign pi.pi_di = r_di;
    assign dirty    = r_dirty;
    assign cmt_ack  = (r_state == S_EXEC);

    assign w_prg_n = r_live[1][3:0];
    assign w_srm_n = r_live[1][7:4];
    assign w_chr_n = r_live[2][3:0];

    // Mask decode from live: (1 << n) - 1, saturating to all ones once n reaches the width.
    always_comb begin
        prg_msk  = (32'(w_prg_n) >= 32'(PRG_MW)) ? '1 : PRG_MW'((32'd1 << w_prg_n) - 32'd1);
        srm_msk  = (32'(w_srm_n) >= 32'(SRM_MW)) ? '1 : SRM_MW'((32'd1 << w_srm_n) - 32'd1);
        chr_msk  = (32'(w_chr_n) >= 32'(CHR_MW)) ? '1 : CHR_MW'((32'd1 << w_chr_n) - 32'd1);
        srm_size = 19'((32'd1 << w_srm_n) << 7);
        map_idx  = {r_live[2][7:4], r_live[0]};
        ctrl     = r_live[7];
        map_cfg  = r_live[4];
    end
endmodule
